// File: rtl/control_sequencer_if.sv
// Bundle between the microcode sequencer and the datapath it steers:
// instruction/flag inputs, the c_* control word, and debug status.
interface control_sequencer_if #(
    parameter int STEP_WIDTH = 3
);
    logic [7:0]            instr;
    logic                  flag_c;
    logic                  flag_z;

    logic                  c_ai, c_ao, c_bi, c_bo, c_zi, c_zo;
    logic                  c_ii, c_io;
    logic                  c_co, c_ce, c_j;
    logic                  c_eo, c_su, c_fi;
    logic                  c_mi, c_ro, c_ri;
    logic                  c_oi;

    logic [STEP_WIDTH-1:0] step;
    logic                  halted;

    // Sequencer side: consumes the instruction register and flags, drives the control word
    modport master (
        input  instr, flag_c, flag_z,
        output c_ai, c_ao, c_bi, c_bo, c_zi, c_zo,
        output c_ii, c_io, c_co, c_ce, c_j,
        output c_eo, c_su, c_fi, c_mi, c_ro, c_ri, c_oi,
        output step, halted
    );

    // Datapath side
    modport slave (
        output instr, flag_c, flag_z,
        input  c_ai, c_ao, c_bi, c_bo, c_zi, c_zo,
        input  c_ii, c_io, c_co, c_ce, c_j,
        input  c_eo, c_su, c_fi, c_mi, c_ro, c_ri, c_oi,
        input  step, halted
    );
endinterface

// File: rtl/control_sequencer.sv
// Microcode sequencer: a T-step counter advanced on the falling clock edge and a
// combinational decode of (step, opcode, flags) into the datapath control word.
module control_sequencer #(
    parameter int STEP_WIDTH   = 3,
    parameter int OPCODE_WIDTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    control_sequencer_if.master bus
);

    typedef enum logic [STEP_WIDTH-1:0] {
        T0 = STEP_WIDTH'(0),
        T1 = STEP_WIDTH'(1),
        T2 = STEP_WIDTH'(2),
        T3 = STEP_WIDTH'(3),
        T4 = STEP_WIDTH'(4)
    } step_e;

    typedef enum logic [OPCODE_WIDTH-1:0] {
        OP_NOP = OPCODE_WIDTH'(4'h0),
        OP_LDA = OPCODE_WIDTH'(4'h1),
        OP_ADD = OPCODE_WIDTH'(4'h2),
        OP_SUB = OPCODE_WIDTH'(4'h3),
        OP_STA = OPCODE_WIDTH'(4'h4),
        OP_LDI = OPCODE_WIDTH'(4'h5),
        OP_JMP = OPCODE_WIDTH'(4'h6),
        OP_JC  = OPCODE_WIDTH'(4'h7),
        OP_JZ  = OPCODE_WIDTH'(4'h8),
        OP_OUT = OPCODE_WIDTH'(4'hE),
        OP_HLT = OPCODE_WIDTH'(4'hF)
    } opcode_e;

    typedef struct packed {
        logic ai, ao, bi, bo, zi, zo;
        logic ii, io;
        logic co, ce, j;
        logic eo, su, fi;
        logic mi, ro, ri;
        logic oi;
    } ctrl_t;

    step_e   step_q, step_d;
    logic    halted_q, halted_d;
    logic    run_q;
    opcode_e opcode;
    ctrl_t   cw;

    assign opcode = opcode_e'(bus.instr[7 -: OPCODE_WIDTH]);

    // The operand nibble is driven onto the bus by the datapath, not decoded here
    logic unused_operand;
    assign unused_operand = ^bus.instr[3:0];

    // Final T-step of each instruction; NOP and undefined opcodes end after fetch
    function automatic step_e last_step(input opcode_e op);
        case (op)
            OP_ADD, OP_SUB:                                   return T4;
            OP_LDA, OP_STA:                                   return T3;
            OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT:     return T2;
            default:                                          return T1;
        endcase
    endfunction

    // run_q holds the control word at zero until the first falling edge after
    // reset release, so release is only ever observed on a clock edge.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            run_q    <= 1'b0;
            step_q   <= T0;
            halted_q <= 1'b0;
        end else begin
            run_q    <= 1'b1;
            step_q   <= step_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        // NOTE: defaults first, so every path assigns every output and no latch is inferred.
        cw       = '0;
        step_d   = T0;
        halted_d = halted_q;

        if (run_q && !halted_q) begin
            case (step_q)
                T0: begin
                    cw.co = 1'b1;
                    cw.mi = 1'b1;
                end
                T1: begin
                    cw.ro = 1'b1;
                    cw.ii = 1'b1;
                    cw.ce = 1'b1;
                end
                T2: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            cw.io = 1'b1;
                            cw.mi = 1'b1;
                        end
                        OP_LDI: begin
                            cw.io = 1'b1;
                            cw.ai = 1'b1;
                        end
                        OP_JMP: begin
                            cw.io = 1'b1;
                            cw.j  = 1'b1;
                        end
                        OP_JC: begin
                            cw.io = bus.flag_c;
                            cw.j  = bus.flag_c;
                        end
                        OP_JZ: begin
                            cw.io = bus.flag_z;
                            cw.j  = bus.flag_z;
                        end
                        OP_OUT: begin
                            cw.ao = 1'b1;
                            cw.oi = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T3: begin
                    case (opcode)
                        OP_LDA: begin
                            cw.ro = 1'b1;
                            cw.ai = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            cw.ro = 1'b1;
                            cw.bi = 1'b1;
                        end
                        OP_STA: begin
                            cw.ao = 1'b1;
                            cw.ri = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T4: begin
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        cw.eo = 1'b1;
                        cw.ai = 1'b1;
                        cw.fi = 1'b1;
                        cw.su = (opcode == OP_SUB);
                    end
                end
                default: ;  // illegal step: all-zero word, counter recovers to T0
            endcase

            if (step_q <= T4 && step_q != last_step(opcode)) begin
                step_d = step_e'(step_q + 1'b1);
            end else if (step_q == last_step(opcode) && opcode == OP_HLT) begin
                halted_d = 1'b1;
            end
        end
    end

    assign bus.c_ai   = cw.ai;
    assign bus.c_ao   = cw.ao;
    assign bus.c_bi   = cw.bi;
    assign bus.c_bo   = cw.bo;
    assign bus.c_zi   = cw.zi;
    assign bus.c_zo   = cw.zo;
    assign bus.c_ii   = cw.ii;
    assign bus.c_io   = cw.io;
    assign bus.c_co   = cw.co;
    assign bus.c_ce   = cw.ce;
    assign bus.c_j    = cw.j;
    assign bus.c_eo   = cw.eo;
    assign bus.c_su   = cw.su;
    assign bus.c_fi   = cw.fi;
    assign bus.c_mi   = cw.mi;
    assign bus.c_ro   = cw.ro;
    assign bus.c_ri   = cw.ri;
    assign bus.c_oi   = cw.oi;
    assign bus.step   = step_q;
    assign bus.halted = halted_q;

endmodule
